ddr_axi_rd_ctrl: RTL

AXI4 read master that fetches the four video channels' frame data from DDR in fixed-length bursts and writes the returned beats straight into `ddr_rd_buf` over the `buf_wr_en` / `buf_wr_data` interface. It sits directly upstream of `ddr_rd_buf`:
- it reads from the channel region selected by `channel_sel`;
- it throttles on `axi_wr_buf_wait`;
- it keeps an independent read pointer per channel, so the downstream mosaic can interleave channels freely.

---
 rtl/ddr_axi_rd_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ddr_axi_rd_ctrl.sv
// AXI4 read master that streams fixed-length bursts of per-channel frame data from DDR
// into ddr_rd_buf, keeping an independent read offset for each of the four channels.
module ddr_axi_rd_ctrl #(
  parameter int DQ_WIDTH        = 32,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int BURST_LEN       = 16,
  parameter int H_WIDTH         = 1280,
  parameter int H_HEIGHT        = 720,
  parameter int CH_STRIDE_LOG2  = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 channel_sel,
  input  logic                       axi_wr_buf_wait,
  input  logic                       frame_sync,
  output logic [CTRL_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                 arlen,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DQ_WIDTH*8-1:0]      rdata,
  input  logic                       rvalid,
  input  logic                       rlast,
  output logic                       rready,
  output logic                       buf_wr_en,
  output logic [DQ_WIDTH*8-1:0]      buf_wr_data,
  output logic                       frame_done
);

  localparam int DATA_W      = DQ_WIDTH * 8;
  localparam int NUM_CH      = 4;
  localparam int FRAME_BYTES = H_WIDTH * H_HEIGHT * 2;
  localparam int OFS_W       = $clog2(FRAME_BYTES);
  localparam int BSTEP       = BURST_LEN * DQ_WIDTH;

  localparam logic [OFS_W-1:0] BSTEP_V = OFS_W'(BSTEP);
  localparam logic [OFS_W-1:0] FRAME_V = OFS_W'(FRAME_BYTES);
  localparam logic [OFS_W-1:0] OFS_ZERO = OFS_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 cur_ch_q, cur_ch_d;
  logic [CTRL_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic                       buf_wr_en_q, buf_wr_en_d;
  logic [DATA_W-1:0]          buf_wr_data_q, buf_wr_data_d;
  logic                       frame_done_q, frame_done_d;
  logic                       sync_pend_q, sync_pend_d;
  logic [OFS_W-1:0]           ofs_q [NUM_CH];
  logic [OFS_W-1:0]           ofs_d [NUM_CH];

  logic                       clear_s;
  logic                       bump_s;
  logic                       beat_s;
  logic [OFS_W-1:0]           next_ofs_s;

  // Channel n occupies a 2^CH_STRIDE_LOG2-byte region starting at n << CH_STRIDE_LOG2.
  function automatic logic [CTRL_ADDR_WIDTH-1:0] chan_addr(input logic [1:0] ch,
                                                           input logic [OFS_W-1:0] ofs);
    chan_addr = (CTRL_ADDR_WIDTH'(ch) << CH_STRIDE_LOG2) + CTRL_ADDR_WIDTH'(ofs);
  endfunction

  assign araddr      = araddr_q;
  assign arlen       = 8'(BURST_LEN - 1);
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign buf_wr_en   = buf_wr_en_q;
  assign buf_wr_data = buf_wr_data_q;
  assign frame_done  = frame_done_q;

  assign beat_s     = rvalid & rready_q;
  assign next_ofs_s = ofs_q[cur_ch_q] + BSTEP_V;

  // Next-state, handshake and offset bookkeeping for the single outstanding burst.
  always_comb begin
    state_d       = state_q;
    cur_ch_d      = cur_ch_q;
    araddr_d      = araddr_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    buf_wr_en_d   = 1'b0;
    buf_wr_data_d = buf_wr_data_q;
    frame_done_d  = 1'b0;
    sync_pend_d   = sync_pend_q;
    clear_s       = 1'b0;
    bump_s        = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ofs_d[i] = ofs_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (!axi_wr_buf_wait) begin
          state_d   = ST_ADDR;
          cur_ch_d  = channel_sel;
          araddr_d  = chan_addr(channel_sel, ofs_q[channel_sel]);
          arvalid_d = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
        clear_s = frame_sync;
      end
      ST_ADDR: begin
        // The presented araddr stays put even if a sync clears the offsets now.
        if (arready) begin
          state_d   = ST_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d   = ST_ADDR;
        end
        clear_s = frame_sync;
      end
      ST_DATA: begin
        if (beat_s) begin
          buf_wr_en_d   = 1'b1;
          buf_wr_data_d = rdata;
        end else begin
          buf_wr_en_d   = 1'b0;
        end
        if (beat_s && rlast) begin
          state_d  = ST_IDLE;
          rready_d = 1'b0;
          if (sync_pend_q || frame_sync) begin
            clear_s     = 1'b1;
            sync_pend_d = 1'b0;
          end else begin
            bump_s      = 1'b1;
          end
        end else begin
          sync_pend_d = sync_pend_q | frame_sync;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        sync_pend_d = 1'b0;
      end
    endcase

    if (clear_s) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ofs_d[i] = OFS_ZERO;
      end
    end else if (bump_s) begin
      if (next_ofs_s == FRAME_V) begin
        ofs_d[cur_ch_q] = OFS_ZERO;
        frame_done_d    = 1'b1;
      end else begin
        ofs_d[cur_ch_q] = next_ofs_s;
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // State and registered outputs; the asynchronous reset clears the AXI handshakes at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cur_ch_q      <= 2'd0;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_data_q <= '0;
      frame_done_q  <= 1'b0;
      sync_pend_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ofs_q[i] <= OFS_ZERO;
      end
    end else begin
      state_q       <= state_d;
      cur_ch_q      <= cur_ch_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_data_q <= buf_wr_data_d;
      frame_done_q  <= frame_done_d;
      sync_pend_q   <= sync_pend_d;
      for (int i = 0; i < NUM_CH; i++) begin
        ofs_q[i] <= ofs_d[i];
      end
    end
  end

endmodule
